// File: rtl/compare_monitor.sv
// ---------------------------------------------------------------------------
// compare_monitor
//
// Watches the output of an external 4-bit magnitude comparator. Each strobed
// sample (A, B and the three comparator flags) is checked for consistency:
// exactly one flag must be high and it must agree with the unsigned
// relation between A and B. Consistent samples update outcome statistics and
// a run-length tracker; inconsistent ones raise a sticky error.
//
// Parameters
//   CNT_W       width of each outcome counter (saturating)
//   STREAK_LEN  run length that raises streak_alert (2..15)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              sample strobe
//   A, B                  operands seen by the comparator
//   Equality, A_greater,
//   B_greater             comparator flags under test
//   clear                 synchronous clear of all statistics (beats in_valid)
//   eq_count, agt_count,
//   bgt_count             accepted-outcome counters
//   max_val               largest operand in any accepted sample
//   streak_alert          run length currently equals STREAK_LEN
//   err_flag              sticky: some sample was rejected
//   out_valid             one-cycle pulse per processed sample
// ---------------------------------------------------------------------------
module compare_monitor #(
   parameter int CNT_W      = 8,
   parameter int STREAK_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       A,
   input  logic [3:0]       B,
   input  logic             Equality,
   input  logic             A_greater,
   input  logic             B_greater,
   input  logic             clear,
   output logic [CNT_W-1:0] eq_count,
   output logic [CNT_W-1:0] agt_count,
   output logic [CNT_W-1:0] bgt_count,
   output logic [3:0]       max_val,
   output logic             streak_alert,
   output logic             err_flag,
   output logic             out_valid
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_EQ  = 2'd1,
      RUN_AGT = 2'd2,
      RUN_BGT = 2'd3
   } state_t;

   localparam logic [3:0]       STREAK  = 4'(STREAK_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t     state_reg;
   logic [3:0] run_len_reg;

   logic       one_hot;
   logic       accepted;
   state_t     outcome;
   logic [3:0] run_len_next;
   logic [3:0] max_next;

   // Sample qualification, run-length successor and running maximum.
   always_comb begin
      one_hot  = ({Equality, A_greater, B_greater} == 3'b100) ||
                 ({Equality, A_greater, B_greater} == 3'b010) ||
                 ({Equality, A_greater, B_greater} == 3'b001);
      accepted = one_hot &&
                 ((Equality  && (A == B)) ||
                  (A_greater && (A >  B)) ||
                  (B_greater && (A <  B)));

      // Only meaningful when the sample is accepted (never IDLE then).
      outcome = IDLE;
      if (Equality)
         outcome = RUN_EQ;
      else if (A_greater)
         outcome = RUN_AGT;
      else if (B_greater)
         outcome = RUN_BGT;

      // Same outcome extends the run (saturating), a new one restarts at 1.
      run_len_next = 4'd1;
      if (outcome == state_reg)
         run_len_next = (run_len_reg == STREAK) ? STREAK : run_len_reg + 4'd1;

      max_next = max_val;
      if (A > max_next)
         max_next = A;
      if (B > max_next)
         max_next = B;
   end

   // Run FSM, statistics and all outputs live in one registered block so
   // every output reflects the sample captured on the preceding edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         run_len_reg  <= 4'd0;
         eq_count     <= '0;
         agt_count    <= '0;
         bgt_count    <= '0;
         max_val      <= 4'd0;
         streak_alert <= 1'b0;
         err_flag     <= 1'b0;
         out_valid    <= 1'b0;
      end else if (clear) begin
         // Clear wins over a coincident sample, which is dropped silently.
         state_reg    <= IDLE;
         run_len_reg  <= 4'd0;
         eq_count     <= '0;
         agt_count    <= '0;
         bgt_count    <= '0;
         max_val      <= 4'd0;
         streak_alert <= 1'b0;
         err_flag     <= 1'b0;
         out_valid    <= 1'b0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         if (accepted) begin
            case (outcome)
               RUN_EQ:  if (eq_count  != CNT_MAX) eq_count  <= eq_count  + CNT_ONE;
               RUN_AGT: if (agt_count != CNT_MAX) agt_count <= agt_count + CNT_ONE;
               RUN_BGT: if (bgt_count != CNT_MAX) bgt_count <= bgt_count + CNT_ONE;
               default: ;
            endcase
            max_val      <= max_next;
            state_reg    <= outcome;
            run_len_reg  <= run_len_next;
            streak_alert <= (run_len_next == STREAK);
         end else begin
            // Inconsistent comparator output breaks any run.
            err_flag     <= 1'b1;
            state_reg    <= IDLE;
            run_len_reg  <= 4'd0;
            streak_alert <= 1'b0;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/compare_monitor.md
COMPARE_MONITOR -- requirements
Module: compare_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each outcome counter.
REQ-002 SHALL have parameter STREAK_LEN, default 3: consecutive identical outcomes needed to raise streak_alert; legal range 2..15.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: sample strobe; A, B and flags are captured when high at a clk rising edge.
REQ-006 SHALL have port A  input  4: unsigned operand presented to the upstream comparator.
REQ-007 SHALL have port B  input  4: unsigned operand presented to the upstream comparator.
REQ-008 SHALL have port Equality  input  1: comparator flag, A equals B.
REQ-009 SHALL have port A_greater  input  1: comparator flag, A greater than B.
REQ-010 SHALL have port B_greater  input  1: comparator flag, B greater than A.
REQ-011 SHALL have port clear  input  1: synchronous clear of all statistics.
REQ-012 SHALL have port eq_count  output  CNT_W: number of accepted equal samples.
REQ-013 SHALL have port agt_count  output  CNT_W: number of accepted A-greater samples.
REQ-014 SHALL have port bgt_count  output  CNT_W: number of accepted B-greater samples.
REQ-015 SHALL have port max_val  output  4: largest operand value seen in any accepted sample.
REQ-016 SHALL have port streak_alert  output  1: high while the current run length equals STREAK_LEN.
REQ-017 SHALL have port err_flag  output  1: sticky error, set by any rejected sample.
REQ-018 SHALL have port out_valid  output  1: one-cycle pulse, outputs updated for a captured sample.

Function
REQ-019 All outputs SHALL be registered; the effect of a sample captured at edge N SHALL be visible after edge N, with out_valid high for exactly that one cycle.
REQ-020 A sample SHALL be accepted only if exactly one flag is high and that flag matches the unsigned comparison of A and B.
REQ-021 A rejected sample SHALL set err_flag, leave counters and max_val unchanged, force the run FSM to IDLE with run length 0, and still pulse out_valid.
REQ-022 An accepted sample SHALL increment exactly one counter; each counter SHALL saturate at all-ones and never wrap.
REQ-023 An accepted sample SHALL set max_val to the maximum of max_val, A and B.
REQ-024 The run FSM SHALL have states IDLE, RUN_EQ, RUN_AGT and RUN_BGT, plus a 4-bit run length.
REQ-025 From any state, an accepted outcome different from the current run SHALL move the FSM to that outcome's RUN state with run length 1.
REQ-026 An accepted outcome equal to the current run SHALL increment the run length, saturating at STREAK_LEN.
REQ-027 streak_alert SHALL be 1 exactly when run length equals STREAK_LEN, and SHALL fall on the first differing or rejected sample.
REQ-028 With in_valid low, all state SHALL hold and out_valid SHALL be 0.
REQ-029 clear SHALL zero counters, max_val, err_flag, streak_alert and run length, and set the FSM to IDLE.
REQ-030 If clear and in_valid are high in the same cycle, clear SHALL win, the sample SHALL be discarded, and out_valid SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately, without a clk edge, force all counters, max_val, streak_alert, err_flag and out_valid to 0 and the FSM to IDLE.
REQ-032 Reset asserted mid-run SHALL discard any in-flight sample; the first sample after reset release SHALL be treated as the first ever.

Verification
REQ-033 After reset, send accepted samples (0,0,Eq), (12,4,Agt), (3,10,Bgt) -> eq/agt/bgt counts 1/1/1, max_val 12, three out_valid pulses, streak_alert 0.
REQ-034 With STREAK_LEN=3, send (7,7,Eq) three times, then (11,4,Agt) -> streak_alert rises the cycle after the third sample and falls after the Agt sample.
REQ-035 Send A=5, B=2 with Equality=1, then flags 000, then flags 110 -> err_flag 1 and sticky, counts unchanged, FSM IDLE, three out_valid pulses.
REQ-036 Send 260 accepted Agt samples -> agt_count reaches 255 and holds, other counts 0.
REQ-037 Assert clear together with in_valid on (9,9,Eq) after prior activity -> all statistics 0, out_valid 0.
REQ-038 Drop rst_n between clock edges during a run of length 2 -> outputs 0 before the next edge; after release, one Eq sample gives run length 1 and eq_count 1.
